// File: rtl/demux4_router_pkg.sv
// Shared constants for the 1-to-4 demultiplexing router: bus widths, channel
// count, slot state encodings and a select decoder.
package demux4_router_pkg;

    localparam int ADDRESS_BUS_WIDTH = 16;
    localparam int DATA_BUS_WIDTH    = 32;
    localparam int NUM_CH            = 4;
    localparam int SEL_W             = 2;
    localparam int COUNT_W           = 8;

    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;

    // Slot holding-state encodings.
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    // One-hot channel mask for a select value.
    function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// One-entry holding slot for a single router channel (EMPTY/FULL), with an
// optional saturating drain counter built only when DEMUX4_COUNT_EN is defined.
module demux4_slot
    import demux4_router_pkg::*;
#(
    parameter int WIDTH = ADDRESS_BUS_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               ready_i,
    output logic [0:0]         state_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count_o
`endif
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;

    assign drain = (state_q == SLOT_FULL) && ready_i;

    // A load wins over a drain so a simultaneous hand-over keeps the slot FULL.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign state_o = state_q;
    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

`ifdef DEMUX4_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (drain && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: rtl/demux4_router.sv
// 1-to-4 valid/ready demultiplexer: routes each accepted word into the
// one-entry slot picked by in_select. Optional counters: DEMUX4_COUNT_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. in_ready is combinational from the selected slot state and its sink's
// out_ready, never from in_valid; a source must hold its word until accepted.
module demux4_router
    import demux4_router_pkg::*;
#(
    parameter int WIDTH = ADDRESS_BUS_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_select,
    output logic [NUM_CH-1:0]  out_valid,
    input  logic [NUM_CH-1:0]  out_ready,
    output logic [WIDTH-1:0]   out_data0,
    output logic [WIDTH-1:0]   out_data1,
    output logic [WIDTH-1:0]   out_data2,
    output logic [WIDTH-1:0]   out_data3
`ifdef DEMUX4_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count0,
    output logic [COUNT_W-1:0] count1,
    output logic [COUNT_W-1:0] count2,
    output logic [COUNT_W-1:0] count3
`endif
);

    logic [0:0]        slot_state [NUM_CH];
    logic [WIDTH-1:0]  slot_data  [NUM_CH];
    logic [NUM_CH-1:0] load;
    logic              in_fire;

    // The selected slot can take a word if empty or if it is draining now.
    assign in_ready = (slot_state[in_select] == SLOT_EMPTY) || out_ready[in_select];
    assign in_fire  = in_valid && in_ready;
    assign load     = in_fire ? sel_onehot(in_select) : '0;

`ifdef DEMUX4_COUNT_EN
    logic [COUNT_W-1:0] slot_count [NUM_CH];
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux4_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[g]),
            .data_i  (in_data),
            .ready_i (out_ready[g]),
            .state_o (slot_state[g]),
            .valid_o (out_valid[g]),
            .data_o  (slot_data[g])
`ifdef DEMUX4_COUNT_EN
            ,
            .count_o (slot_count[g])
`endif
        );
    end

    assign out_data0 = slot_data[0];
    assign out_data1 = slot_data[1];
    assign out_data2 = slot_data[2];
    assign out_data3 = slot_data[3];

`ifdef DEMUX4_COUNT_EN
    assign count0 = slot_count[0];
    assign count1 = slot_count[1];
    assign count2 = slot_count[2];
    assign count3 = slot_count[3];
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Self-checking bench for demux4_router: per-channel expected queues checked
// every cycle, plus directed literal checks and a randomized 1000-word run.
module tb_demux4_router;
  import demux4_router_pkg::*;

  localparam int W = ADDRESS_BUS_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [1:0]       in_select = '0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [W-1:0]     out_data0, out_data1, out_data2, out_data3;
  logic [W-1:0]     od [4];
`ifdef DEMUX4_COUNT_EN
  logic [7:0]       count0, count1, count2, count3;
  logic [7:0]       cnt_o [4];
  assign cnt_o[0] = count0;
  assign cnt_o[1] = count1;
  assign cnt_o[2] = count2;
  assign cnt_o[3] = count3;
`endif

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  demux4_router #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_select (in_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX4_COUNT_EN
    ,
    .count0    (count0),
    .count1    (count1),
    .count2    (count2),
    .count3    (count3)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [4][$];
  int exp_cnt [4];
  int pushes = 0;
  int pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check outputs against the queues, then advance the
  // queues by the transfers the coming rising edge will perform.
  always @(negedge clk) begin
    logic [3:0] ev;
    logic       er;
    if (!rst_n) begin
      chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
        chk("rst_out_data", {16'd0, od[i]}, 32'd0);
`ifdef DEMUX4_COUNT_EN
        chk("rst_count", {24'd0, cnt_o[i]}, 32'd0);
`endif
        exp_q[i].delete();
        exp_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) ev[i] = (exp_q[i].size() != 0);
      er = (exp_q[in_select].size() == 0) || out_ready[in_select];
      chk("model_out_valid", {28'd0, out_valid}, {28'd0, ev});
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, er});
      for (int i = 0; i < 4; i++) begin
        if (ev[i]) chk("model_out_data", {16'd0, od[i]}, {16'd0, exp_q[i][0]});
`ifdef DEMUX4_COUNT_EN
        chk("model_count", {24'd0, cnt_o[i]}, exp_cnt[i]);
`endif
      end
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && out_ready[i]) begin
          void'(exp_q[i].pop_front());
          pops++;
          if (exp_cnt[i] < 255) exp_cnt[i]++;
        end
      end
      if (in_valid && er) begin
        exp_q[in_select].push_back(in_data);
        pushes++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                       input logic [3:0] ordy);
    in_valid  = v;
    in_select = sel;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    drive(1'b0, 2'd0, '0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int target;
    drive(1'b0, 2'd0, '0, 4'b0000);
    #2;
    chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data2", {16'd0, out_data2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

    // Single word to channel 2, no drain.
    drive(1'b1, 2'd2, 16'h1234, 4'b0000);
    step();
    chk("ch2_out_valid", {28'd0, out_valid}, 32'h4);
    chk("ch2_out_data2", {16'd0, out_data2}, 32'h1234);
    chk("ch2_in_ready_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 2'd1, 16'h0055, 4'b0000);
    step();
    chk("ch1_loaded", {28'd0, out_valid}, 32'h6);

    // Channel 1 hand-over: drain and reload in one cycle.
    drive(1'b1, 2'd1, 16'h00AA, 4'b0010);
    #1;
    chk("handover_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("handover_valid1", {31'd0, out_valid[1]}, 32'd1);
    chk("handover_data1", {16'd0, out_data1}, 32'h00AA);
    drive(1'b0, 2'd0, '0, 4'b1111);
    step();
    chk("drain_all", {28'd0, out_valid}, 32'd0);
    chk("drain_hold_data1", {16'd0, out_data1}, 32'h00AA);

    // Channel 0 stalled while channel 3 is loaded.
    drive(1'b1, 2'd0, 16'h0F0F, 4'b0000);
    step();
    drive(1'b1, 2'd3, 16'h3333, 4'b0000);
    #1;
    chk("ch3_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("ch0_ch3_valid", {28'd0, out_valid}, 32'h9);
    chk("ch0_data_kept", {16'd0, out_data0}, 32'h0F0F);
    chk("ch3_data", {16'd0, out_data3}, 32'h3333);

    // Fill all slots, then reset mid-cycle.
    drive(1'b1, 2'd1, 16'h1111, 4'b0000);
    step();
    drive(1'b1, 2'd2, 16'h2222, 4'b0000);
    step();
    drive(1'b0, 2'd0, '0, 4'b0000);
    chk("all_full", {28'd0, out_valid}, 32'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'd0);
    chk("async_rst_data0", {16'd0, out_data0}, 32'd0);
    chk("async_rst_data3", {16'd0, out_data3}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();

`ifdef DEMUX4_COUNT_EN
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 2'd0, W'(n), 4'b0001);
      step();
    end
    drive(1'b0, 2'd0, '0, 4'b0001);
    step();
    chk("count0_sat", {24'd0, count0}, 32'd255);
    chk("count1_zero", {24'd0, count1}, 32'd0);
    chk("count2_zero", {24'd0, count2}, 32'd0);
    chk("count3_zero", {24'd0, count3}, 32'd0);
    do_reset();
    chk("count0_cleared", {24'd0, count0}, 32'd0);
`endif

    // Randomized routing with random backpressure.
    target = pushes + 1000;
    budget = 20000;
    while (pushes < target && budget > 0) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            W'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
      step();
      budget--;
    end
    chk("random_budget", {31'd0, budget > 0}, 32'd1);
    drive(1'b0, 2'd0, '0, 4'b1111);
    step();
    step();
    chk("random_drained", {28'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) chk("random_queue_empty", exp_q[i].size(), 32'd0);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_router.md
DEMUX4_ROUTER -- requirements
Module: demux4_router

Interface
REQ-001 Parameter: WIDTH, default ADDRESS_BUS_WIDTH (from params.v), width of the routed data word; instantiate with DATA_BUS_WIDTH for data routing.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  source presents a word.
REQ-005 in_ready  output  1  router accepts the word this cycle.
REQ-006 in_data  input  WIDTH  word to route.
REQ-007 in_select  input  2  destination channel 0..3.
REQ-008 out_valid  output  4  bit i: channel i holds a word.
REQ-009 out_ready  input  4  bit i: channel i sink takes the word this cycle.
REQ-010 out_data0..out_data3  output  WIDTH each  per-channel held word.
REQ-011 count0..count3  output  8 each  per-channel transfer count; present only with DEMUX4_COUNT_EN.

Function
REQ-012 Input transfer occurs when in_valid && in_ready; output transfer on channel i occurs when out_valid[i] && out_ready[i].
REQ-013 Each channel has a one-entry holding slot with states EMPTY and FULL; out_valid[i] is 1 exactly when slot i is FULL.
REQ-014 in_ready is combinational: 1 when slot[in_select] is EMPTY, or FULL and out_ready[in_select] is 1 in the same cycle; in_ready does not depend on in_valid.
REQ-015 Latency: a word accepted at edge N appears on out_data[in_select] with out_valid set after edge N (one cycle).
REQ-016 EMPTY -> FULL on input transfer to that channel; FULL -> EMPTY on output transfer with no input transfer to that channel; FULL stays FULL and reloads data on simultaneous output and input transfer (no bubble).
REQ-017 At most one channel is loaded per cycle; other channels drain independently in the same cycle.
REQ-018 out_data[i] holds its value while FULL and out_ready[i] is 0; it is not cleared on drain (value after drain is don't-care to sinks but stable).
REQ-019 Words to one channel are delivered in acceptance order; no ordering is guaranteed across channels.
REQ-020 in_select and in_data are sampled only on an input transfer; changes while in_ready is 0 have no effect.
REQ-021 A word is never dropped or duplicated: every input transfer yields exactly one output transfer on the selected channel.

Reset
REQ-022 While rst_n is 0: all slots EMPTY, out_valid = 4'b0000, out_data0..3 = 0, count0..3 = 0; in_ready therefore reads 1.
REQ-023 Assertion mid-operation discards any held words immediately and asynchronously; first accept is possible on the first rising edge after deassertion.

Configuration
REQ-024 Macro DEMUX4_COUNT_EN defined: count ports exist; count[i] increments by 1 on each output transfer of channel i, saturates at 255, cleared only by reset.
REQ-025 Macro DEMUX4_COUNT_EN undefined: count ports and counter logic absent; all other behaviour identical.

Structure
REQ-026 params.v holds ADDRESS_BUS_WIDTH, DATA_BUS_WIDTH, channel-count constant (4) and slot state encodings (EMPTY=0, FULL=1).
REQ-027 One sub-module demux4_slot (one-entry buffer: load, drain, valid, data, optional counter), instantiated four times; demux4_router holds only decode and in_ready logic.

Verification
REQ-028 Reset, then in_valid=1, in_select=2, in_data=0x1234, out_ready=0 -> after one edge out_valid=4'b0100, out_data2=0x1234; next cycle with same select in_ready=0.
REQ-029 Channel 1 FULL, out_ready[1]=1, new word 0x00AA to channel 1 same cycle -> in_ready=1, out_valid[1] stays 1, out_data1=0x00AA next cycle.
REQ-030 Channel 0 FULL and stalled, word to channel 3 -> accepted, out_valid=4'b1001; channel 0 data unchanged.
REQ-031 Random in_select/out_ready backpressure over 1000 words -> per-channel scoreboard matches in order, no loss or duplication.
REQ-032 rst_n pulsed low with all four slots FULL -> out_valid=0 immediately, out_data0..3=0, in_ready=1.
REQ-033 With DEMUX4_COUNT_EN, 300 drains on channel 0 -> count0=255, count1..3=0.
